// File: rtl/ttt_display_formatter_pkg.sv
// ttt_display_formatter_pkg: digit-code fields, glyphs, FSM states and BCD helper
package ttt_display_formatter_pkg;
  localparam int EN_BIT = 5;
  localparam int HEX_LSB = 1;
  localparam int DP_BIT = 0;
  localparam logic [5:0] BLANK = 6'b000000;
  localparam logic [3:0] GLYPH_P1 = 4'h1;
  localparam logic [3:0] GLYPH_P2 = 4'h2;
  localparam logic [3:0] GLYPH_DRAW = 4'hD;
  typedef enum logic [1:0] {PLAY, WIN, DRAW} state_t;
  typedef logic [7:0][5:0] digits_t;
  function automatic logic [5:0] digit(input logic en, input logic [3:0] hex, input logic dp);
    logic [5:0] d;
    d = BLANK;
    d[EN_BIT] = en;
    d[HEX_LSB+:4] = hex;
    d[DP_BIT] = dp;
    return d;
  endfunction
  // Two-digit BCD step: clear wins over increment, 99 saturates
  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic clr, input logic inc);
    return clr ? 8'h00 :
           (!inc || v == 8'h99) ? v :
           (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'h0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/ttt_display_formatter_if.sv
// ttt_display_formatter_if: game events in, player/busy/digit codes out
interface ttt_display_formatter_if;
  logic move_valid;
  logic win;
  logic draw;
  logic new_game;
  logic clear_scores;
  logic cur_player;
  logic busy;
  logic [5:0] i0, i1, i2, i3, i4, i5, i6, i7;
  modport master (
    output move_valid, win, draw, new_game, clear_scores,
    input cur_player, busy, i0, i1, i2, i3, i4, i5, i6, i7
  );
  modport slave (
    input move_valid, win, draw, new_game, clear_scores,
    output cur_player, busy, i0, i1, i2, i3, i4, i5, i6, i7
  );
endinterface

// File: rtl/ttt_display_formatter_bcd_counter_2d.sv
// bcd_counter_2d: two-digit BCD score counter saturating at 99
module bcd_counter_2d
  import ttt_display_formatter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  always_ff @(posedge clk) begin
    if (reset) {tens, ones} <= 8'h00;
    else {tens, ones} <= bcd_next({tens, ones}, clr, inc);
  end
endmodule

// File: rtl/ttt_display_formatter.sv
// ttt_display_formatter: game FSM, blink timer and registered 8-digit display codes
module ttt_display_formatter
  import ttt_display_formatter_pkg::*;
#(
  parameter int BLINK_TICKS = 50_000_000,
  parameter int BLINK_COUNT = 6
) (
  input logic clk,
  input logic reset,
  ttt_display_formatter_if.slave bus
);
  localparam int TW = $clog2(BLINK_TICKS);
  localparam int BW = $clog2(BLINK_COUNT + 1);
  state_t state, state_n;
  logic cur_player, cp_n, phase, ph_n, inc1, inc2, tick, restart;
  logic [3:0] move_cnt, mc_n, p1_tens, p1_ones, p2_tens, p2_ones;
  logic [TW-1:0] timer, tm_n;
  logic [BW-1:0] blink_cnt, bc_n;
  logic [7:0] p1_n, p2_n;
  digits_t digits;
  bcd_counter_2d u_p1 (.clk(clk), .reset(reset), .clr(bus.clear_scores), .inc(inc1), .tens(p1_tens), .ones(p1_ones));
  bcd_counter_2d u_p2 (.clk(clk), .reset(reset), .clr(bus.clear_scores), .inc(inc2), .tens(p2_tens), .ones(p2_ones));
  // Display is built from next-state values so events show one cycle later
  function automatic digits_t layout(input state_t st, input logic cp, input logic [3:0] mc,
                                     input logic ph, input logic [7:0] s1, input logic [7:0] s2);
    digits_t d;
    logic hide1, hide2;
    hide1 = st == WIN && !ph && !cp;
    hide2 = st == WIN && !ph && cp;
    d[7] = hide1 ? BLANK : digit(s1[7:4] != 4'd0, s1[7:4], 1'b0);
    d[6] = hide1 ? BLANK : digit(1'b1, s1[3:0], 1'b0);
    d[5] = BLANK;
    d[4] = (st == WIN && !ph) ? BLANK : digit(1'b1, cp ? GLYPH_P2 : GLYPH_P1, 1'b1);
    d[3] = digit(1'b1, st == DRAW ? GLYPH_DRAW : mc, 1'b0);
    d[2] = BLANK;
    d[1] = hide2 ? BLANK : digit(s2[7:4] != 4'd0, s2[7:4], 1'b0);
    d[0] = hide2 ? BLANK : digit(1'b1, s2[3:0], 1'b0);
    return (st == DRAW && !ph) ? '0 : d;
  endfunction
  always_comb begin
    state_n = state;
    cp_n = cur_player;
    mc_n = move_cnt;
    tm_n = timer;
    ph_n = phase;
    bc_n = blink_cnt;
    inc1 = 1'b0;
    inc2 = 1'b0;
    tick = timer == TW'(BLINK_TICKS - 1);
    restart = bus.new_game || (state != PLAY && tick && blink_cnt == BW'(BLINK_COUNT - 1));
    if (restart) begin
      state_n = PLAY;
      cp_n = 1'b0;
      mc_n = 4'd0;
      tm_n = '0;
      ph_n = 1'b1;
      bc_n = '0;
    end else if (state == PLAY) begin
      if (bus.win || bus.draw) begin
        state_n = bus.win ? WIN : DRAW;
        inc1 = bus.win && !cur_player;
        inc2 = bus.win && cur_player;
        tm_n = '0;
        ph_n = 1'b1;
        bc_n = '0;
      end else if (bus.move_valid) begin
        cp_n = !cur_player;
        mc_n = move_cnt == 4'd9 ? 4'd9 : move_cnt + 4'd1;
      end
    end else if (tick) begin
      tm_n = '0;
      ph_n = !phase;
      bc_n = blink_cnt + BW'(1);
    end else begin
      tm_n = timer + TW'(1);
    end
    p1_n = bcd_next({p1_tens, p1_ones}, bus.clear_scores, inc1);
    p2_n = bcd_next({p2_tens, p2_ones}, bus.clear_scores, inc2);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PLAY;
      cur_player <= 1'b0;
      move_cnt <= 4'd0;
      timer <= '0;
      phase <= 1'b1;
      blink_cnt <= '0;
      digits <= layout(PLAY, 1'b0, 4'd0, 1'b1, 8'h00, 8'h00);
    end else begin
      state <= state_n;
      cur_player <= cp_n;
      move_cnt <= mc_n;
      timer <= tm_n;
      phase <= ph_n;
      blink_cnt <= bc_n;
      digits <= layout(state_n, cp_n, mc_n, ph_n, p1_n, p2_n);
    end
  end
  assign bus.cur_player = cur_player;
  assign bus.busy = state != PLAY;
  assign {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = digits;
endmodule

// File: tb/tb_ttt_display_formatter.sv
// tb_ttt_display_formatter: directed scoreboard bench with BLINK_TICKS=4, BLINK_COUNT=2
module tb_ttt_display_formatter;
  localparam int CP = 8;
  localparam int BZ = 9;
  typedef struct {
    string tag;
    int idx;
    logic [5:0] exp;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  ttt_display_formatter_if bus ();
  ttt_display_formatter #(.BLINK_TICKS(4), .BLINK_COUNT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [5:0] obs(input int idx);
    case (idx)
      0: return bus.i0;
      1: return bus.i1;
      2: return bus.i2;
      3: return bus.i3;
      4: return bus.i4;
      5: return bus.i5;
      6: return bus.i6;
      7: return bus.i7;
      CP: return {5'd0, bus.cur_player};
      default: return {5'd0, bus.busy};
    endcase
  endfunction
  task automatic expect_v(input string tag, input int idx, input logic [5:0] v);
    exp_t e;
    e.tag = tag;
    e.idx = idx;
    e.exp = v;
    sbq.push_back(e);
  endtask
  task automatic cyc(input int n);
    exp_t e;
    logic [5:0] o;
    repeat (n) @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.idx);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", e.tag, o, e.exp);
      end
    end
  endtask
  task automatic drive(input logic mv, input logic w, input logic d, input logic ng, input logic cs);
    bus.move_valid = mv;
    bus.win = w;
    bus.draw = d;
    bus.new_game = ng;
    bus.clear_scores = cs;
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic expect_reset(input string tag);
    expect_v({tag, "_i7"}, 7, 6'b000000);
    expect_v({tag, "_i6"}, 6, 6'b100000);
    expect_v({tag, "_i5"}, 5, 6'b000000);
    expect_v({tag, "_i4"}, 4, 6'b100011);
    expect_v({tag, "_i3"}, 3, 6'b100000);
    expect_v({tag, "_i2"}, 2, 6'b000000);
    expect_v({tag, "_i1"}, 1, 6'b000000);
    expect_v({tag, "_i0"}, 0, 6'b100000);
    expect_v({tag, "_cp"}, CP, 6'd0);
    expect_v({tag, "_busy"}, BZ, 6'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    expect_reset("rst");
    cyc(2);
    reset = 1'b0;
    expect_reset("idle");
    cyc(3);
    // three moves
    repeat (2) begin drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1); idle(); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_v("mv3_cp", CP, 6'd1);
    expect_v("mv3_i4", 4, 6'b100101);
    expect_v("mv3_i3", 3, 6'b100110);
    expect_v("mv3_busy", BZ, 6'd0);
    cyc(1); idle();
    // fourth move returns to P1, then P1 wins
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1); idle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_v("win_busy", BZ, 6'd1);
    expect_v("win_i6", 6, 6'b100010);
    expect_v("win_i7", 7, 6'b000000);
    expect_v("win_i4", 4, 6'b100011);
    expect_v("win_i3", 3, 6'b101000);
    cyc(1); idle();
    expect_v("win_lit_i6", 6, 6'b100010);
    cyc(3);
    expect_v("win_blank_i6", 6, 6'b000000);
    expect_v("win_blank_i4", 4, 6'b000000);
    expect_v("win_static_i3", 3, 6'b101000);
    expect_v("win_blank_busy", BZ, 6'd1);
    cyc(1);
    expect_v("win_still_blank_i6", 6, 6'b000000);
    cyc(3);
    expect_v("auto_busy", BZ, 6'd0);
    expect_v("auto_i6", 6, 6'b100010);
    expect_v("auto_i4", 4, 6'b100011);
    expect_v("auto_i3", 3, 6'b100000);
    cyc(1);
    // preload P2 to 99 via quick win/new_game rounds
    for (int i = 0; i < 99; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1); idle();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 8) begin
        expect_v("p2_09_i1", 1, 6'b000000);
        expect_v("p2_09_i0", 0, 6'b110010);
      end
      if (i == 9) begin
        expect_v("p2_10_i1", 1, 6'b100010);
        expect_v("p2_10_i0", 0, 6'b100000);
      end
      cyc(1); idle();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); cyc(1); idle();
    end
    expect_v("p2_99_i1", 1, 6'b110010);
    expect_v("p2_99_i0", 0, 6'b110010);
    cyc(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1); idle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_v("sat_busy", BZ, 6'd1);
    expect_v("sat_i1", 1, 6'b110010);
    expect_v("sat_i0", 0, 6'b110010);
    expect_v("sat_i3", 3, 6'b100010);
    expect_v("sat_i4", 4, 6'b100101);
    expect_v("sat_cp", CP, 6'd1);
    cyc(1); idle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_v("ng_busy", BZ, 6'd0);
    expect_v("ng_cp", CP, 6'd0);
    cyc(1); idle();
    // draw and early new game
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_v("draw_i3", 3, 6'b111010);
    expect_v("draw_busy", BZ, 6'd1);
    expect_v("draw_i6", 6, 6'b100010);
    cyc(1); idle();
    cyc(3);
    expect_v("draw_blank_i6", 6, 6'b000000);
    expect_v("draw_blank_i4", 4, 6'b000000);
    expect_v("draw_blank_i3", 3, 6'b000000);
    expect_v("draw_blank_i1", 1, 6'b000000);
    expect_v("draw_blank_i0", 0, 6'b000000);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_v("dng_busy", BZ, 6'd0);
    expect_v("dng_i6", 6, 6'b100010);
    expect_v("dng_i1", 1, 6'b110010);
    expect_v("dng_i0", 0, 6'b110010);
    expect_v("dng_i3", 3, 6'b100000);
    expect_v("dng_i4", 4, 6'b100011);
    cyc(1); idle();
    // new_game beats win in PLAY
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_v("ngw_busy", BZ, 6'd0);
    expect_v("ngw_i6", 6, 6'b100010);
    cyc(1); idle();
    // clear with P2 win, then reset mid-blink
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1); idle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_v("clr_busy", BZ, 6'd1);
    expect_v("clr_i1", 1, 6'b000000);
    expect_v("clr_i0", 0, 6'b100000);
    expect_v("clr_i6", 6, 6'b100000);
    expect_v("clr_i4", 4, 6'b100101);
    cyc(1); idle();
    cyc(2);
    reset = 1'b1;
    expect_reset("rst2");
    cyc(1);
    reset = 1'b0;
    expect_reset("post_rst");
    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
